poc_printer_system: RTL and testbench
=====================================

Name: poc_printer_system

Overview:
- Top-level parallel-output-controller (POC) subsystem with three internal units:
  - a processor model, which moves `i_data` bytes into the POC over a register bus;
  - the POC, which holds status register SR and buffer register BR and runs the printer handshake;
  - a printer model, which latches each byte and is busy for a fixed time.
- `i_mode` selects polling (0) or interrupt-driven (1) transfer. All internal buses are exported for observation.

Parameters:
- PRINT_CYCLES, 4, cycles the printer holds `o_rdy` low after accepting a byte (minimum 1).

Ports:
- i_clk, input, 1, system clock; all logic on the rising edge.
- i_rst_n, input, 1, reset: synchronous and active-high, sampled on `i_clk`. Name kept per codebase; the polarity is active-high despite the suffix.
- i_data, input, 8, byte offered for printing; sampled when the processor writes BR.
- i_mode, input, 1, 0 = polling, 1 = interrupt.
- o_tr, output, 1, POC-to-printer transfer request.
- o_pd, output, 8, POC-to-printer parallel data.
- o_rdy, output, 1, printer ready.
- o_data, output, 8, last byte latched by the printer.
- o_rw, output, 1, processor bus direction (1 = write, 0 = read).
- o_addr, output, 1, register select (0 = SR, 1 = BR).
- o_irq, output, 1, POC interrupt request, active-low.
- o_data_poc_to_processor, output, 8, POC read-data bus.
- o_data_processor_to_poc, output, 8, processor write-data bus.

Behaviour:
- Reset (i_rst_n=1 at a clock edge) sets:
  - SR=0x80, BR=0x00;
  - o_tr=0, o_pd=0x00;
  - o_rdy=1, o_data=0x00;
  - o_irq=1, o_rw=0, o_addr=0;
  - both data buses = 0x00;
  - all FSMs to IDLE, interrupt-enabled flag cleared.
  - Reset mid-transfer aborts the transfer immediately.
- SR bit meanings: bit7 = ready flag, bit0 = interrupt enable, other bits write-through, reset 0.
- Bus timing:
  - Write: POC loads the selected register from `o_data_processor_to_poc` at the edge where o_rw=1.
  - Read: `o_data_poc_to_processor` = o_addr ? BR : SR, combinational. The processor registers it at the end of the read cycle.
  - Each bus access lasts exactly one cycle. o_rw returns to 0 when idle.
- `o_irq` = ~(SR[7] & SR[0]), combinational.
- Processor FSM states: IDLE, READ_SR, CHECK, ENABLE, WRITE_BR, WRITE_SR.
  - Polling (i_mode=0):
    - IDLE → READ_SR (o_addr=0, o_rw=0) → CHECK.
    - In CHECK: if the captured SR[7]=1 → WRITE_BR, else → IDLE.
    - WRITE_BR: o_addr=1, o_rw=1, write bus = i_data.
    - WRITE_SR: o_addr=0, o_rw=1, write bus = 0x00.
    - Then → IDLE. Entering mode 0 clears the enabled flag.
  - Interrupt (i_mode=1):
    - In IDLE, if the enabled flag is clear → ENABLE: write SR=0x81, set the flag, → IDLE.
    - Otherwise, if o_irq=0 → WRITE_BR (as above), then WRITE_SR with value 0x01.
    - Otherwise stay in IDLE.
  - i_mode is sampled only in IDLE; a change mid-sequence takes effect at the next IDLE.
- POC FSM states: IDLE, WAIT_RDY, SEND, WAIT_DONE.
  - IDLE: when SR[7]=0 → WAIT_RDY.
  - WAIT_RDY: when o_rdy=1 → SEND.
  - SEND: o_pd=BR, o_tr=1 for exactly one cycle → WAIT_DONE.
  - WAIT_DONE: first waits for o_rdy=0, then for o_rdy=1, then sets SR[7]=1 → IDLE.
  - o_pd holds its last value between sends.
  - If the processor writes SR in the same cycle the POC sets SR[7], the processor write wins.
- Printer:
  - When o_tr=1 and o_rdy=1: o_data ← o_pd, o_rdy ← 0.
  - It counts PRINT_CYCLES cycles, then sets o_rdy ← 1.
  - o_tr while busy is ignored.
- Throughput:
  - Polling: one byte per ≥ PRINT_CYCLES+6 cycles.
  - No byte is lost or duplicated; each BR write results in exactly one o_tr pulse.

Test Plan:
- Reset: assert i_rst_n=1 for 2 cycles with activity → every output equals the listed reset values; SR reads 0x80.
- Polling: mode 0, i_data=0x0F at the WRITE_BR cycle → o_pd=0x0F with a single-cycle o_tr pulse; o_data=0x0F one cycle later; o_rdy low for 4 cycles; SR[7] returns to 1.
- Interrupt: reset, then mode 1 → a single write of SR=0x81 occurs, then o_irq=0. The processor writes BR and SR=0x01, o_irq returns to 1, and it drops again after the printer finishes.
- Repeating stimulus 0x01,0x03,0x07,0x0F,0x1F,0x00 (one value per cycle) → o_data sequence equals the values sampled at the WRITE_BR cycles; count of o_tr pulses equals count of BR writes.
- Reset during WAIT_DONE → outputs return to reset values next cycle; a new transfer completes normally.
- Busy printer: force an extra o_tr while o_rdy=0 → o_data unchanged.

Source files
------------

// File: rtl/poc_printer_system.sv
// Parallel-output-controller subsystem: processor model, POC (SR/BR + printer handshake)
// and printer model, with every internal bus exported for observation.
module poc_printer_system #(
   parameter int PRINT_CYCLES = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_data,
   input  logic       i_mode,
   output logic       o_tr,
   output logic [7:0] o_pd,
   output logic       o_rdy,
   output logic [7:0] o_data,
   output logic       o_rw,
   output logic       o_addr,
   output logic       o_irq,
   output logic [7:0] o_data_poc_to_processor,
   output logic [7:0] o_data_processor_to_poc
);

   localparam logic [2:0] P_IDLE     = 3'd0;
   localparam logic [2:0] P_READ_SR  = 3'd1;
   localparam logic [2:0] P_CHECK    = 3'd2;
   localparam logic [2:0] P_ENABLE   = 3'd3;
   localparam logic [2:0] P_WRITE_BR = 3'd4;
   localparam logic [2:0] P_WRITE_SR = 3'd5;

   localparam logic [1:0] C_IDLE      = 2'd0;
   localparam logic [1:0] C_WAIT_RDY  = 2'd1;
   localparam logic [1:0] C_SEND      = 2'd2;
   localparam logic [1:0] C_WAIT_DONE = 2'd3;

   localparam int             CW       = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LOAD = CW'(PRINT_CYCLES - 1);

   logic [2:0]    r_pstate;
   logic          r_cap_rdy;
   logic          r_en;
   logic          r_mode;
   logic [1:0]    r_cstate;
   logic [7:0]    r_sr;
   logic [7:0]    r_br;
   logic          r_busy_seen;
   logic          r_tr;
   logic [7:0]    r_pd;
   logic          r_rdy;
   logic [7:0]    r_data;
   logic [CW-1:0] r_cnt;

   assign o_tr   = r_tr;
   assign o_pd   = r_pd;
   assign o_rdy  = r_rdy;
   assign o_data = r_data;

   assign o_data_poc_to_processor = o_addr ? r_br : r_sr;
   assign o_irq                   = ~(r_sr[7] & r_sr[0]);

   // Processor bus is a pure decode of the processor state: one cycle per access.
   always_comb begin
      // NOTE: every output gets a default first so no state leaves it unassigned (no latch).
      o_rw                    = 1'b0;
      o_addr                  = 1'b0;
      o_data_processor_to_poc = 8'h00;
      case (r_pstate)
         P_ENABLE: begin
            o_rw                    = 1'b1;
            o_data_processor_to_poc = 8'h81;
         end
         P_WRITE_BR: begin
            o_rw                    = 1'b1;
            o_addr                  = 1'b1;
            o_data_processor_to_poc = i_data;
         end
         P_WRITE_SR: begin
            o_rw                    = 1'b1;
            o_data_processor_to_poc = r_mode ? 8'h01 : 8'h00;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         r_pstate  <= P_IDLE;
         r_cap_rdy <= 1'b0;
         r_en      <= 1'b0;
         r_mode    <= 1'b0;
      end else begin
         case (r_pstate)
            P_IDLE: begin
               r_mode <= i_mode;
               if (!i_mode) begin
                  r_en     <= 1'b0;
                  r_pstate <= P_READ_SR;
               end else if (!r_en) begin
                  r_pstate <= P_ENABLE;
               end else if (!o_irq) begin
                  r_pstate <= P_WRITE_BR;
               end
            end
            P_READ_SR: begin
               r_cap_rdy <= o_data_poc_to_processor[7];
               r_pstate  <= P_CHECK;
            end
            P_CHECK:    r_pstate <= r_cap_rdy ? P_WRITE_BR : P_IDLE;
            P_ENABLE: begin
               r_en     <= 1'b1;
               r_pstate <= P_IDLE;
            end
            P_WRITE_BR: r_pstate <= P_WRITE_SR;
            default:    r_pstate <= P_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         r_cstate    <= C_IDLE;
         r_sr        <= 8'h80;
         r_br        <= 8'h00;
         r_busy_seen <= 1'b0;
         r_tr        <= 1'b0;
         r_pd        <= 8'h00;
      end else begin
         r_tr <= 1'b0;
         case (r_cstate)
            C_IDLE:     if (!r_sr[7]) r_cstate <= C_WAIT_RDY;
            C_WAIT_RDY: if (o_rdy) begin
               r_pd     <= r_br;
               r_tr     <= 1'b1;
               r_cstate <= C_SEND;
            end
            C_SEND: begin
               r_busy_seen <= 1'b0;
               r_cstate    <= C_WAIT_DONE;
            end
            default: begin
               if (!r_busy_seen) begin
                  if (!o_rdy) r_busy_seen <= 1'b1;
               end else if (o_rdy) begin
                  r_sr[7]     <= 1'b1;
                  r_busy_seen <= 1'b0;
                  r_cstate    <= C_IDLE;
               end
            end
         endcase
         // NOTE: the bus write is last so it overrides a same-cycle ready-flag set.
         if (o_rw) begin
            if (o_addr) r_br <= o_data_processor_to_poc;
            else        r_sr <= o_data_processor_to_poc;
         end
      end
   end

   // Printer: requests arriving while busy are ignored.
   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         r_rdy  <= 1'b1;
         r_data <= 8'h00;
         r_cnt  <= '0;
      end else if (r_rdy) begin
         if (o_tr) begin
            r_data <= o_pd;
            r_rdy  <= 1'b0;
            r_cnt  <= CNT_LOAD;
         end
      end else if (r_cnt == '0) begin
         r_rdy <= 1'b1;
      end else begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

endmodule

// File: tb/tb_poc_printer_system.sv
// Randomized bench for poc_printer_system: scenario tasks plus a byte-queue scoreboard
// that follows every BR write through to the printer.
module tb_poc_printer_system;

   localparam int PC = 4;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b1;
   logic [7:0] i_data = 8'h00;
   logic       i_mode = 1'b0;
   logic       o_tr, o_rdy, o_rw, o_addr, o_irq;
   logic [7:0] o_pd, o_data, o_data_poc_to_processor, o_data_processor_to_poc;

   int vectors = 0;
   int miscompares = 0;

   poc_printer_system #(.PRINT_CYCLES(PC)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_mode(i_mode),
      .o_tr(o_tr), .o_pd(o_pd), .o_rdy(o_rdy), .o_data(o_data),
      .o_rw(o_rw), .o_addr(o_addr), .o_irq(o_irq),
      .o_data_poc_to_processor(o_data_poc_to_processor),
      .o_data_processor_to_poc(o_data_processor_to_poc)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: bytes written to BR must reach the printer once each, in order.
   logic       mon_en = 1'b0;
   logic [7:0] sb_q[$];
   int         br_writes, tr_pulses, en_writes, low_cnt;
   logic       pend, prev_tr;
   logic [7:0] pend_exp, exp_b;

   always @(negedge i_clk) begin
      if (mon_en) begin
         if (o_rw && o_addr) begin
            sb_q.push_back(i_data);
            br_writes++;
         end
         if (o_rw && !o_addr && o_data_processor_to_poc == 8'h81) en_writes++;
         if (pend) begin
            vectors++;
            if (o_data !== pend_exp || o_rdy !== 1'b0) begin
               miscompares++;
               $display("FAIL sb_accept: o_data=%h o_rdy=%b, expected o_data=%h o_rdy=0", o_data, o_rdy, pend_exp);
            end
            pend = 1'b0;
         end
         if (o_tr) begin
            tr_pulses++;
            vectors++;
            if (prev_tr || !o_rdy || sb_q.size() == 0) begin
               miscompares++;
               $display("FAIL sb_tr_pulse: prev_tr=%b o_rdy=%b queued=%0d, expected 0/1/>0", prev_tr, o_rdy, sb_q.size());
            end else begin
               exp_b = sb_q.pop_front();
               if (o_pd !== exp_b) begin
                  miscompares++;
                  $display("FAIL sb_pd: o_pd=%h expected %h", o_pd, exp_b);
               end
               pend     = 1'b1;
               pend_exp = exp_b;
            end
         end
         prev_tr = o_tr;
         if (!o_rdy) low_cnt++;
         else if (low_cnt != 0) begin
            vectors++;
            if (low_cnt != PC) begin
               miscompares++;
               $display("FAIL sb_busy_len: o_rdy low %0d cycles, expected %0d", low_cnt, PC);
            end
            low_cnt = 0;
         end
         if (!o_addr) begin
            vectors++;
            if (o_irq !== ~(o_data_poc_to_processor[7] & o_data_poc_to_processor[0])) begin
               miscompares++;
               $display("FAIL sb_irq: o_irq=%b with SR=%h", o_irq, o_data_poc_to_processor);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic mon_clear();
      sb_q.delete();
      br_writes = 0; tr_pulses = 0; en_writes = 0; low_cnt = 0;
      pend = 1'b0; prev_tr = 1'b0;
   endtask

   task automatic do_reset(input int n);
      mon_en  = 1'b0;
      i_rst_n = 1'b1;
      repeat (n) cyc();
      i_rst_n = 1'b0;
      mon_clear();
      mon_en  = 1'b1;
   endtask

   task automatic wait_tr(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (o_tr) begin
            ok = 1'b1;
            return;
         end
         cyc();
      end
      ok = o_tr;
   endtask

   task automatic check_reset_values(input string tag);
      logic [36:0] got, want;
      got  = {o_tr, o_pd, o_rdy, o_data, o_irq, o_rw, o_addr, o_data_poc_to_processor, o_data_processor_to_poc};
      want = {1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 8'h00};
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: outputs=%h expected %h", tag, got, want);
      end
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      i_mode  = 1'b0;
      for (int k = 0; k < 20; k++) begin
         i_data = 8'($urandom);
         cyc();
      end
      mon_en  = 1'b0;
      i_rst_n = 1'b1;
      cyc();
      cyc();
      i_rst_n = 1'b0;
      check_reset_values("reset_values");
   endtask

   task automatic test_polling();
      bit ok;
      int low;
      i_mode = 1'b0;
      i_data = 8'h0F;
      do_reset(1);
      wait_tr(60, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL poll_tr_timeout: no o_tr seen, expected one");
         return;
      end
      if (o_pd !== 8'h0F) begin
         miscompares++;
         $display("FAIL poll_pd: o_pd=%h expected 0f", o_pd);
      end
      cyc();
      vectors++;
      if ({o_tr, o_data, o_rdy} !== {1'b0, 8'h0F, 1'b0}) begin
         miscompares++;
         $display("FAIL poll_accept: tr/data/rdy=%b/%h/%b expected 0/0f/0", o_tr, o_data, o_rdy);
      end
      low = 1;
      for (int i = 0; i < 20 && !o_rdy; i++) begin
         cyc();
         if (!o_rdy) low++;
      end
      vectors++;
      if (low != PC) begin
         miscompares++;
         $display("FAIL poll_busy_len: o_rdy low %0d cycles, expected %0d", low, PC);
      end
      cyc();
      vectors++;
      if ({o_addr, o_data_poc_to_processor[7]} !== 2'b01) begin
         miscompares++;
         $display("FAIL poll_sr_ready: addr/SR7=%b/%b expected 0/1", o_addr, o_data_poc_to_processor[7]);
      end
   endtask

   task automatic test_interrupt();
      logic [7:0] d;
      bit ok;
      d      = 8'($urandom);
      i_data = d;
      i_mode = 1'b1;
      do_reset(1);
      cyc();
      vectors++;
      if ({o_rw, o_addr, o_data_processor_to_poc} !== {1'b1, 1'b0, 8'h81}) begin
         miscompares++;
         $display("FAIL int_enable: rw/addr/wdata=%b/%b/%h expected 1/0/81", o_rw, o_addr, o_data_processor_to_poc);
      end
      cyc();
      vectors++;
      if ({o_irq, o_rw} !== 2'b00) begin
         miscompares++;
         $display("FAIL int_irq_low: irq/rw=%b/%b expected 0/0", o_irq, o_rw);
      end
      cyc();
      vectors++;
      if ({o_rw, o_addr, o_data_processor_to_poc} !== {1'b1, 1'b1, d}) begin
         miscompares++;
         $display("FAIL int_write_br: rw/addr/wdata=%b/%b/%h expected 1/1/%h", o_rw, o_addr, o_data_processor_to_poc, d);
      end
      cyc();
      vectors++;
      if ({o_rw, o_addr, o_data_processor_to_poc} !== {1'b1, 1'b0, 8'h01}) begin
         miscompares++;
         $display("FAIL int_write_sr: rw/addr/wdata=%b/%b/%h expected 1/0/01", o_rw, o_addr, o_data_processor_to_poc);
      end
      cyc();
      vectors++;
      if (o_irq !== 1'b1) begin
         miscompares++;
         $display("FAIL int_irq_high: o_irq=%b expected 1", o_irq);
      end
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (!o_irq) begin
            ok = 1'b1;
            break;
         end
      end
      vectors++;
      if (!ok || o_data !== d || en_writes != 1) begin
         miscompares++;
         $display("FAIL int_done: irq_dropped=%b o_data=%h enable_writes=%0d expected 1/%h/1", ok, o_data, en_writes, d);
      end
   endtask

   task automatic test_stream();
      logic [7:0] pat[6];
      bit drained;
      pat = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h00};
      for (int seg = 0; seg < 4; seg++) begin
         i_mode = (seg < 2) ? seg[0] : 1'($urandom);
         do_reset(1);
         for (int k = 0; k < 300; k++) begin
            i_data = (seg < 2) ? pat[k % 6] : 8'($urandom);
            cyc();
         end
         drained = 1'b0;
         for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0 && !pend) begin
               drained = 1'b1;
               break;
            end
            cyc();
         end
         vectors++;
         if (!drained || tr_pulses != br_writes || br_writes == 0) begin
            miscompares++;
            $display("FAIL stream_counts seg%0d: drained=%b tr=%0d br_writes=%0d expected 1, equal, >0", seg, drained, tr_pulses, br_writes);
         end
      end
   endtask

   task automatic test_reset_wait_done();
      bit ok;
      i_mode = 1'b0;
      i_data = 8'h3C;
      do_reset(1);
      wait_tr(60, ok);
      cyc();
      mon_en  = 1'b0;
      i_rst_n = 1'b1;
      cyc();
      i_rst_n = 1'b0;
      check_reset_values("reset_mid_transfer");
      i_data = 8'hC3;
      mon_clear();
      mon_en = 1'b1;
      wait_tr(60, ok);
      vectors++;
      if (!ok || o_pd !== 8'hC3) begin
         miscompares++;
         $display("FAIL rst_new_send: tr_seen=%b o_pd=%h expected 1/c3", ok, o_pd);
      end
      cyc();
      vectors++;
      if (o_data !== 8'hC3) begin
         miscompares++;
         $display("FAIL rst_new_data: o_data=%h expected c3", o_data);
      end
   endtask

   task automatic test_busy_printer();
      bit ok;
      int low;
      i_mode = 1'b0;
      i_data = 8'h5A;
      do_reset(1);
      mon_en = 1'b0;
      wait_tr(60, ok);
      cyc();
      low = 1;
      force dut.o_tr = 1'b1;
      force dut.o_pd = 8'hA5;
      cyc();
      release dut.o_tr;
      release dut.o_pd;
      if (!o_rdy) low++;
      vectors++;
      if (!ok || {o_data, o_rdy} !== {8'h5A, 1'b0}) begin
         miscompares++;
         $display("FAIL busy_ignore: tr_seen=%b data/rdy=%h/%b expected 1 5a/0", ok, o_data, o_rdy);
      end
      for (int i = 0; i < 20 && !o_rdy; i++) begin
         cyc();
         if (!o_rdy) low++;
      end
      vectors++;
      if (low != PC || o_data !== 8'h5A) begin
         miscompares++;
         $display("FAIL busy_len: o_rdy low %0d cycles data=%h, expected %0d cycles data=5a", low, o_data, PC);
      end
   endtask

   initial begin
      mon_clear();
      cyc();
      test_reset();
      test_polling();
      test_interrupt();
      test_stream();
      test_reset_wait_done();
      test_busy_printer();
      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
